// File: rtl/jtkicker_dwnld_pkg.sv
// Shared types and constants for the Kicker ROM-download transformer.
package jtkicker_dwnld_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_NSWAP = 2'd1;
  localparam logic [1:0] MODE_OBJIL = 2'd2;
  localparam logic [1:0] MODE_DROP  = 2'd3;

  typedef struct packed {
    logic        prom;
    logic [24:0] dst;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StPstb
  } state_t;

endpackage

// File: rtl/jtkicker_dwnld_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module jtkicker_dwnld_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // Storage needs no reset: the pointers define which slots are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/jtkicker_dwnld_xform.sv
// ROM-download transformer: per-region byte/address remap, FIFO buffering and
// SDRAM (acked) or PROM (strobed) write-out.
module jtkicker_dwnld_xform
  import jtkicker_dwnld_pkg::*;
#(
  parameter int unsigned        NREG       = 4,
  parameter logic [NREG*25-1:0] REG_START  = '0,
  parameter logic [NREG*2-1:0]  REG_MODE   = '0,
  parameter logic [24:0]        PROM_START = 25'h1C000,
  parameter int unsigned        PROM_AW    = 11,
  parameter int unsigned        DEPTH      = 4,
  parameter logic               SWAB       = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               downloading,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               ioctl_wr,
  output logic [21:0]        prog_addr,
  output logic [15:0]        prog_data,
  output logic [1:0]         prog_mask,
  output logic               prog_we,
  input  logic               sdram_ack,
  output logic               prom_we,
  output logic [PROM_AW-1:0] prom_addr,
  output logic [7:0]         prom_data,
  output logic               dwnld_busy,
  output logic               overflow
);

  entry_t       w_in;
  entry_t       w_head;
  logic [1:0]   w_mode;
  logic         w_is_prom;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_lost;
  logic         w_dl_rise;
  logic         w_unused;
  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_dl_prev;
  logic         r_overflow;
  logic [21:0]  r_prog_addr;
  logic [15:0]  r_prog_data;
  logic [1:0]   r_prog_mask;
  logic [PROM_AW-1:0] r_prom_addr;
  logic [7:0]   r_prom_data;

  // Region select and transform of the incoming byte.
  always_comb begin
    w_mode = MODE_PASS;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (ioctl_addr >= REG_START[25*k +: 25]) w_mode = REG_MODE[2*k +: 2];
    end
    w_is_prom = (ioctl_addr >= PROM_START);
    w_in.prom = w_is_prom;
    w_in.dst  = ioctl_addr;
    w_in.data = ioctl_dout;
    if (w_is_prom) begin
      w_in.dst = ioctl_addr - PROM_START;
    end else begin
      case (w_mode)
        MODE_NSWAP: w_in.data = {ioctl_dout[3:0], ioctl_dout[7:4]};
        MODE_OBJIL: begin
          w_in.dst[15]  = ioctl_addr[0];
          w_in.dst[14]  = ioctl_addr[15];
          w_in.dst[0]   = ~ioctl_addr[14];
          w_in.dst[2:1] = ioctl_addr[5:4] + 2'd1;
          w_in.dst[6:3] = {ioctl_addr[6], ioctl_addr[3:1]};
        end
        default: ;
      endcase
    end
  end

  assign w_push    = ioctl_wr & downloading & (w_is_prom | (w_mode != MODE_DROP));
  assign w_lost    = w_push & w_full & ~w_pop;
  assign w_dl_rise = downloading & ~r_dl_prev;
  assign w_unused  = ^w_head.dst[24:23];

  jtkicker_dwnld_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      StIdle: if (!w_empty) w_state_nxt = w_head.prom ? StPstb : StWr;
      StWr: begin
        if (sdram_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StPstb: begin
        w_pop       = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_dl_prev  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dl_prev <= downloading;
      // A loss in the same cycle as a new download window still counts.
      if (w_lost)         r_overflow <= 1'b1;
      else if (w_dl_rise) r_overflow <= 1'b0;
    end
  end

  // Outputs are captured on launch so they stay put for the whole handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_mask <= 2'b11;
      r_prom_addr <= '0;
      r_prom_data <= '0;
    end else if (r_state == StIdle && !w_empty) begin
      if (w_head.prom) begin
        r_prom_addr <= w_head.dst[PROM_AW-1:0];
        r_prom_data <= w_head.data;
      end else begin
        r_prog_addr <= w_head.dst[22:1];
        r_prog_data <= {w_head.data, w_head.data};
        r_prog_mask <= (w_head.dst[0] ^ SWAB) ? 2'b01 : 2'b10;
      end
    end
  end

  assign prog_we    = (r_state == StWr);
  assign prom_we    = (r_state == StPstb);
  assign prog_addr  = r_prog_addr;
  assign prog_data  = r_prog_data;
  assign prog_mask  = r_prog_mask;
  assign prom_addr  = r_prom_addr;
  assign prom_data  = r_prom_data;
  assign overflow   = r_overflow;
  assign dwnld_busy = downloading | ~w_empty;

endmodule

// File: tb/tb_jtkicker_dwnld_xform.sv
// Self-checking bench: queue-based timing model plus directed literal checks
// and a randomized download stream.
module tb_jtkicker_dwnld_xform;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PROM_AW = 11;
  localparam logic [24:0] PROM_S  = 25'h1C000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        sdram_ack = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic [PROM_AW-1:0] prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy;
  logic        overflow;

  always #5 clk = ~clk;

  jtkicker_dwnld_xform #(
    .NREG       (4),
    .REG_START  ({25'h18000, 25'h10000, 25'h08000, 25'h00000}),
    .REG_MODE   ({2'd3, 2'd2, 2'd1, 2'd0}),
    .PROM_START (PROM_S),
    .PROM_AW    (PROM_AW),
    .DEPTH      (DEPTH),
    .SWAB       (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_ack   (sdram_ack),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          prom;
    logic [21:0] paddr;
    logic [15:0] pdata;
    logic [1:0]  mask;
    logic [10:0] praddr;
    logic [7:0]  prdata;
    int          t;
  } exp_t;

  exp_t mq[$];
  int   head_s = 0;      // cycle at which the head's strobe begins
  int   last_pop = -100;
  int   cyc = 0;         // index of the current cycle since reset release
  bit   m_ovf = 1'b0;
  bit   m_dl_prev = 1'b0;
  bit   m_pop;
  int   m_cnt;
  exp_t m_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int region_of(input logic [24:0] a);
    if (a >= 25'h18000) return 3;
    if (a >= 25'h10000) return 2;
    if (a >= 25'h08000) return 1;
    return 0;
  endfunction

  function automatic bit is_drop(input logic [24:0] a);
    return (a < PROM_S) && (region_of(a) == 3);
  endfunction

  function automatic exp_t xform(input logic [24:0] a, input logic [7:0] d);
    exp_t        e;
    logic [24:0] dst;
    logic [24:0] off;
    logic [7:0]  dd;
    e.prom = 1'b0; e.paddr = '0; e.pdata = '0; e.mask = 2'b11;
    e.praddr = '0; e.prdata = '0; e.t = 0;
    if (a >= PROM_S) begin
      off      = a - PROM_S;
      e.prom   = 1'b1;
      e.praddr = off[10:0];
      e.prdata = d;
    end else begin
      dst = a;
      dd  = d;
      if (region_of(a) == 1) dd = {d[3:0], d[7:4]};
      if (region_of(a) == 2) begin
        dst[15]  = a[0];
        dst[14]  = a[15];
        dst[0]   = ~a[14];
        dst[2:1] = a[5:4] + 2'd1;
        dst[6:3] = {a[6], a[3:1]};
      end
      e.paddr = dst[22:1];
      e.pdata = {dd, dd};
      e.mask  = (dst[0] ^ 1'b1) ? 2'b01 : 2'b10;
    end
    return e;
  endfunction

  // Model: entry pushed in cycle t strobes at max(t+2, previous pop+2);
  // SDRAM entries pop on the first ack at/after that, PROM entries at once.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ovf     = 1'b0;
      m_dl_prev = 1'b0;
      last_pop  = -100;
      cyc       = 0;
      head_s    = 0;
    end else begin
      m_cnt = mq.size();
      m_pop = 1'b0;
      if (m_cnt > 0 && head_s <= cyc) m_pop = mq[0].prom ? 1'b1 : sdram_ack;
      if (m_pop) begin
        void'(mq.pop_front());
        last_pop = cyc;
        if (mq.size() > 0) head_s = imax(mq[0].t + 2, cyc + 2);
      end
      if (downloading && !m_dl_prev) m_ovf = 1'b0;
      if (ioctl_wr && downloading && !is_drop(ioctl_addr)) begin
        if (m_cnt == DEPTH && !m_pop) begin
          m_ovf = 1'b1;
        end else begin
          m_e   = xform(ioctl_addr, ioctl_dout);
          m_e.t = cyc;
          mq.push_back(m_e);
          if (mq.size() == 1) head_s = imax(cyc + 2, last_pop + 2);
        end
      end
      m_dl_prev = downloading;
      cyc++;
    end
  end

  // Compare process: checked on the falling edge every cycle.
  initial forever begin
    bit epw;
    bit emw;
    @(negedge clk);
    epw = 1'b0;
    emw = 1'b0;
    if (mq.size() > 0) begin
      epw = !mq[0].prom && (head_s <= cyc);
      emw = mq[0].prom && (head_s == cyc);
    end
    chk("m_prog_we", 32'(prog_we), 32'(epw));
    chk("m_prom_we", 32'(prom_we), 32'(emw));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_busy", 32'(dwnld_busy), 32'(downloading || (mq.size() > 0)));
    if (epw) begin
      chk("m_prog_addr", 32'(prog_addr), 32'(mq[0].paddr));
      chk("m_prog_data", 32'(prog_data), 32'(mq[0].pdata));
      chk("m_prog_mask", 32'(prog_mask), 32'(mq[0].mask));
    end
    if (emw) begin
      chk("m_prom_addr", 32'(prom_addr), 32'(mq[0].praddr));
      chk("m_prom_data", 32'(prom_data), 32'(mq[0].prdata));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_prog_we"}, 32'(prog_we), 32'd0);
    chk({nm, "_prom_we"}, 32'(prom_we), 32'd0);
    chk({nm, "_prog_mask"}, 32'(prog_mask), 32'h3);
    chk({nm, "_prog_addr"}, 32'(prog_addr), 32'd0);
    chk({nm, "_prog_data"}, 32'(prog_data), 32'd0);
    chk({nm, "_prom_addr"}, 32'(prom_addr), 32'd0);
    chk({nm, "_prom_data"}, 32'(prom_data), 32'd0);
    chk({nm, "_overflow"}, 32'(overflow), 32'd0);
    chk({nm, "_busy"}, 32'(dwnld_busy), 32'(downloading));
  endtask

  task automatic sdram_case(input string nm, input logic [24:0] a, input logic [7:0] d,
                            input logic [21:0] ea, input logic [15:0] ed, input logic [1:0] em);
    tick(); ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(); ioctl_wr = 1'b0; #2;
    chk({nm, "_c1_we"}, 32'(prog_we), 32'd0);
    tick(); #2;
    chk({nm, "_c2_we"}, 32'(prog_we), 32'd1);
    chk({nm, "_addr"}, 32'(prog_addr), 32'(ea));
    chk({nm, "_data"}, 32'(prog_data), 32'(ed));
    chk({nm, "_mask"}, 32'(prog_mask), 32'(em));
    tick(); tick(); #2;
    chk({nm, "_hold_we"}, 32'(prog_we), 32'd1);
    chk({nm, "_hold_addr"}, 32'(prog_addr), 32'(ea));
    sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0; #2;
    chk({nm, "_ack_drop"}, 32'(prog_we), 32'd0);
    tick();
  endtask

  function automatic logic [24:0] rand_addr();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0: return 25'($urandom_range(0, 32'h7FFF));
      1: return 25'(32'h8000 + $urandom_range(0, 32'h7FFF));
      2: return 25'(32'h10000 + $urandom_range(0, 32'h7FFF));
      3: return 25'(32'h18000 + $urandom_range(0, 32'h3FFF));
      default: return 25'(32'h1C000 + $urandom_range(0, 32'h7FF));
    endcase
  endfunction

  initial begin
    int hs;
    #1 rst_n = 1'b0;
    #2 chk_reset_vals("rst");
    tick(); tick(); rst_n = 1'b1;
    tick(); downloading = 1'b1;
    tick(); tick();

    sdram_case("nswap", 25'h8003, 8'hA5, 22'h4001, 16'h5A5A, 2'b10);
    sdram_case("objil", 25'h10000, 8'h3C, 22'h8001, 16'h3C3C, 2'b10);
    sdram_case("pass", 25'h00004, 8'h77, 22'h0002, 16'h7777, 2'b01);

    // PROM strobe
    tick(); ioctl_addr = 25'h1C010; ioctl_dout = 8'h0F; ioctl_wr = 1'b1;
    tick(); ioctl_wr = 1'b0; #2;
    chk("prom_c1_we", 32'(prom_we), 32'd0);
    tick(); #2;
    chk("prom_c2_we", 32'(prom_we), 32'd1);
    chk("prom_addr", 32'(prom_addr), 32'h010);
    chk("prom_data", 32'(prom_data), 32'h0F);
    chk("prom_no_prog", 32'(prog_we), 32'd0);
    tick(); #2;
    chk("prom_c3_we", 32'(prom_we), 32'd0);
    chk("prom_c3_prog", 32'(prog_we), 32'd0);
    tick();

    // Overflow: six back-to-back writes with ack held low
    sdram_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1); ioctl_wr = 1'b1;
    end
    tick(); ioctl_wr = 1'b0; #2;
    chk("ovf_set", 32'(overflow), 32'd1);
    sdram_ack = 1'b1;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (prog_we && sdram_ack) hs++;
      tick(); #2;
    end
    chk("ovf_handshakes", 32'(hs), 32'd4);
    sdram_ack = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    downloading = 1'b0;
    tick(); downloading = 1'b1;
    tick(); #2;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // DROP region and gated writes
    tick(); ioctl_addr = 25'h18005; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    tick(); ioctl_addr = 25'h1A000;
    tick(); downloading = 1'b0; ioctl_addr = 25'h00010;
    tick(); ioctl_wr = 1'b0; #2;
    chk("drop_busy", 32'(dwnld_busy), 32'd0);
    chk("drop_ovf", 32'(overflow), 32'd0);
    tick(); tick(); #2;
    chk("drop_no_we", 32'(prog_we), 32'd0);
    tick(); downloading = 1'b1;
    tick();

    // Reset mid-write with three entries queued
    for (int i = 0; i < 3; i++) begin
      tick(); ioctl_addr = 25'(32'h100 + i); ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    end
    tick(); ioctl_wr = 1'b0; #2;
    chk("mid_we", 32'(prog_we), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    tick(); tick(); rst_n = 1'b1; #1;
    chk("midrst_busy_hi", 32'(dwnld_busy), 32'd1);
    downloading = 1'b0; #1;
    chk("midrst_busy_lo", 32'(dwnld_busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); #2;
      chk("midrst_no_we", 32'(prog_we | prom_we), 32'd0);
    end

    // Randomized stream
    tick(); downloading = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 59) == 0) downloading = ~downloading;
      ioctl_wr   = ($urandom_range(0, 2) == 0);
      ioctl_addr = rand_addr();
      ioctl_dout = 8'($urandom);
      sdram_ack  = ($urandom_range(0, 2) == 0);
    end

    // Drain
    tick(); downloading = 1'b0; ioctl_wr = 1'b0; sdram_ack = 1'b1;
    for (int i = 0; i < 200 && dwnld_busy; i++) tick();
    #2 chk("drain_idle", 32'(dwnld_busy), 32'd0);
    sdram_ack = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
